// File: rtl/acc_fetch_seq_pkg.sv
// Shared definitions for the Apollo fetch sequencer: opcodes, EXTEND word,
// boot address, FSM encoding and the decoded-instruction record.
// Optional build macro: ACC_PARITY_CHECK_EN adds the ERR state.
package acc_fetch_seq_pkg;

  typedef enum logic [2:0] {
    OP_TC    = 3'o0,
    OP_CCS   = 3'o1,
    OP_DAS   = 3'o2,
    OP_CA    = 3'o3,
    OP_CS    = 3'o4,
    OP_INDEX = 3'o5,
    OP_AD    = 3'o6,
    OP_MP    = 3'o7
  } op_t;

  localparam logic [14:0] EXTEND_WORD   = 15'o00006;
  localparam logic [11:0] BOOT_ADDR_DEF = 12'h800;

`ifdef ACC_PARITY_CHECK_EN
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_VALID   = 3'd3,
    ST_ERR     = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_VALID   = 3'd3
  } state_t;
`endif

  typedef struct packed {
    op_t         op;
    logic [1:0]  qc;
    logic [11:0] addr;
  } instr_dec_t;

  // ROM words carry odd parity over all 16 bits
  function automatic logic odd_parity_ok(input logic [15:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/acc_instr_decode.sv
// Combinational field split of a 15-bit instruction word; shared with the
// execute stage so both sides agree on field boundaries.
module acc_instr_decode
  import acc_fetch_seq_pkg::*;
(
  input  logic [14:0] word,
  output instr_dec_t  dec
);

  // qc and addr overlap on purpose: qc is the top of the address field
  always_comb begin
    dec.op   = op_t'(word[14:12]);
    dec.qc   = word[11:10];
    dec.addr = word[11:0];
  end

endmodule

// File: rtl/acc_fetch_seq.sv
// Apollo instruction fetch sequencer: owns the PC, strobes the ROM, folds
// EXTEND prefixes and hands decoded words to execute via valid/ready.
// Optional build macro: ACC_PARITY_CHECK_EN (odd-parity check, sticky ERR).
module acc_fetch_seq
  import acc_fetch_seq_pkg::*;
#(
  parameter int             AW        = 12,
  parameter int             DW        = 16,
  parameter logic [AW-1:0]  BOOT_ADDR = BOOT_ADDR_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          step,
  input  logic          run,
  output logic [AW-1:0] rom_addr,
  output logic          rom_cs,
  input  logic [DW-1:0] rom_data,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [14:0]   instr_word,
  output logic [2:0]    instr_op,
  output logic [1:0]    instr_qc,
  output logic [11:0]   instr_addr,
  output logic          instr_ext,
  input  logic          jump_en,
  input  logic [AW-1:0] jump_addr,
  output logic [AW-1:0] pc,
  output logic          parity_err
);

  state_t     state;
  logic       ext_pend;
  logic       accept;
  instr_dec_t dec;

  assign accept   = instr_valid & instr_ready;
  assign rom_addr = pc;

  acc_instr_decode u_dec (
    .word (instr_word),
    .dec  (dec)
  );

  assign instr_op   = dec.op;
  assign instr_qc   = dec.qc;
  assign instr_addr = dec.addr;

`ifdef ACC_PARITY_CHECK_EN
  logic par_err_q;
  logic par_ok;
  assign par_ok     = odd_parity_ok(rom_data[15:0]);
  assign parity_err = par_err_q;
`else
  // parity bit (and anything above the instruction) is ignored in this build
  logic unused_rom_msb;
  assign unused_rom_msb = ^rom_data[DW-1:15];
  assign parity_err     = 1'b0;
`endif

  // Fetch FSM; all handshake and ROM strobes are registered alongside state
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      pc          <= BOOT_ADDR;
      rom_cs      <= 1'b0;
      instr_valid <= 1'b0;
      instr_word  <= '0;
      instr_ext   <= 1'b0;
      ext_pend    <= 1'b0;
`ifdef ACC_PARITY_CHECK_EN
      par_err_q   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          // step and run together still start only one fetch
          if (step || run) begin
            state  <= ST_FETCH;
            rom_cs <= 1'b1;
          end
        end
        ST_FETCH: begin
          // ROM samples the address on the negedge of this cycle
          state  <= ST_CAPTURE;
          rom_cs <= 1'b0;
        end
        ST_CAPTURE: begin
          instr_word <= rom_data[14:0];
          pc         <= pc + AW'(1);
`ifdef ACC_PARITY_CHECK_EN
          if (!par_ok) begin
            par_err_q <= 1'b1;
            state     <= ST_ERR;
          end else
`endif
          if (rom_data[14:0] == EXTEND_WORD) begin
            // prefix is folded silently: no handshake, straight to next word
            ext_pend <= 1'b1;
            state    <= ST_FETCH;
            rom_cs   <= 1'b1;
          end else begin
            instr_ext   <= ext_pend;
            instr_valid <= 1'b1;
            state       <= ST_VALID;
          end
        end
        ST_VALID: begin
          if (accept) begin
            instr_valid <= 1'b0;
            ext_pend    <= 1'b0;
            if (jump_en) pc <= jump_addr;
            if (run) begin
              state  <= ST_FETCH;
              rom_cs <= 1'b1;
            end else begin
              state  <= ST_IDLE;
            end
          end
        end
`ifdef ACC_PARITY_CHECK_EN
        ST_ERR: begin
          // parked until reset
          state <= ST_ERR;
        end
`endif
        default: begin
          state       <= ST_IDLE;
          rom_cs      <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acc_fetch_seq.sv
// Scoreboard bench for acc_fetch_seq: stimulus queues expected instructions
// and point probes; one negedge monitor owns all comparisons.
module tb_acc_fetch_seq;

  logic        clk = 1'b0;
  logic        rst, step, run, instr_ready, jump_en;
  logic [11:0] jump_addr, rom_addr, pc;
  logic [15:0] rom_data;
  logic        rom_cs, instr_valid, instr_ext, parity_err;
  logic [14:0] instr_word;
  logic [2:0]  instr_op;
  logic [1:0]  instr_qc;
  logic [11:0] instr_addr;

  logic [15:0] rom [0:4095];

  always #5 clk = ~clk;

  acc_fetch_seq dut (
    .clk(clk), .rst(rst), .step(step), .run(run),
    .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_word(instr_word), .instr_op(instr_op), .instr_qc(instr_qc),
    .instr_addr(instr_addr), .instr_ext(instr_ext),
    .jump_en(jump_en), .jump_addr(jump_addr), .pc(pc), .parity_err(parity_err)
  );

  // ROM model: samples address on negedge while selected
  initial rom_data = 16'h0;
  always @(negedge clk) if (rom_cs) rom_data <= rom[rom_addr];

  localparam int S_CS = 0, S_ADDR = 1, S_VLD = 2, S_PC = 3, S_WORD = 4,
                 S_EXT = 5, S_PERR = 6, S_MEAS = 7;

  typedef struct packed {
    int          tag;
    int          sig;
    logic [31:0] want;
    logic [31:0] meas;
  } probe_t;

  typedef struct packed {
    logic [14:0] word;
    logic        ext;
    logic [11:0] pc;
  } exp_t;

  probe_t probe_q[$];
  exp_t   instr_q[$];
  int     n_vec = 0;
  int     n_err = 0;

  function automatic logic [15:0] mk(input logic [14:0] w);
    return {~^w, w};
  endfunction

  function automatic string sig_name(input int s);
    case (s)
      S_CS:    return "rom_cs";
      S_ADDR:  return "rom_addr";
      S_VLD:   return "instr_valid";
      S_PC:    return "pc";
      S_WORD:  return "instr_word";
      S_EXT:   return "instr_ext";
      S_PERR:  return "parity_err";
      default: return "measured";
    endcase
  endfunction

  task automatic chk(input string nm, input int tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL t%0d_%s: got %0h expected %0h", tag, nm, got, want);
    end
  endtask

  // Monitor: resolves probes and checks every accepted instruction
  always @(negedge clk) begin
    probe_t      p;
    exp_t        e;
    logic [31:0] act;
    while (probe_q.size() != 0) begin
      p = probe_q.pop_front();
      case (p.sig)
        S_CS:    act = {31'b0, rom_cs};
        S_ADDR:  act = {20'b0, rom_addr};
        S_VLD:   act = {31'b0, instr_valid};
        S_PC:    act = {20'b0, pc};
        S_WORD:  act = {17'b0, instr_word};
        S_EXT:   act = {31'b0, instr_ext};
        S_PERR:  act = {31'b0, parity_err};
        default: act = p.meas;
      endcase
      chk(sig_name(p.sig), p.tag, act, p.want);
    end
    if (instr_valid && instr_ready) begin
      if (instr_q.size() == 0) begin
        chk("unexpected_accept", 0, {17'b0, instr_word}, 32'hFFFFFFFF);
      end else begin
        e = instr_q.pop_front();
        chk("sb_word", 900, {17'b0, instr_word}, {17'b0, e.word});
        chk("sb_op",   900, {29'b0, instr_op},   {29'b0, e.word[14:12]});
        chk("sb_qc",   900, {30'b0, instr_qc},   {30'b0, e.word[11:10]});
        chk("sb_addr", 900, {20'b0, instr_addr}, {20'b0, e.word[11:0]});
        chk("sb_ext",  900, {31'b0, instr_ext},  {31'b0, e.ext});
        chk("sb_pc",   900, {20'b0, pc},         {20'b0, e.pc});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input int tag, input int sig, input logic [31:0] want);
    probe_q.push_back('{tag: tag, sig: sig, want: want, meas: 32'h0});
  endtask

  task automatic measure(input int tag, input logic [31:0] got, input logic [31:0] want);
    probe_q.push_back('{tag: tag, sig: S_MEAS, want: want, meas: got});
  endtask

  task automatic expect_instr(input logic [14:0] w, input logic x, input logic [11:0] p);
    instr_q.push_back('{word: w, ext: x, pc: p});
  endtask

  task automatic do_reset();
    rst = 1'b1; step = 1'b0; run = 1'b0; jump_en = 1'b0; instr_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1; step = 1'b0; run = 1'b0; instr_ready = 1'b0;
    jump_en = 1'b0; jump_addr = 12'h0;
    for (int i = 0; i < 4096; i++) rom[i] = mk(15'o0);
    tick(); tick();

    // reset state
    probe(1, S_PC, 32'h800);  probe(1, S_CS, 0);   probe(1, S_VLD, 0);
    probe(1, S_WORD, 0);      probe(1, S_EXT, 0);  probe(1, S_PERR, 0);

    // T2: single step, CA 0012
    rom[12'h800] = mk(15'o30012);
    expect_instr(15'o30012, 1'b0, 12'h801);
    rst = 1'b0; step = 1'b1;
    tick(); step = 1'b0;
    probe(2, S_CS, 1); probe(2, S_ADDR, 32'h800); probe(2, S_VLD, 0);
    tick();
    probe(2, S_CS, 0); probe(2, S_VLD, 0);
    tick();
    probe(2, S_VLD, 1); probe(2, S_WORD, 32'o30012); probe(2, S_PC, 32'h801);
    instr_ready = 1'b1;
    tick(); instr_ready = 1'b0;
    probe(2, S_VLD, 0); probe(2, S_CS, 0);

    // T3: two EXTENDs folded into one extended instruction
    rom[12'h800] = mk(15'o00006);
    rom[12'h801] = mk(15'o00006);
    rom[12'h802] = mk(15'o40005);
    do_reset();
    expect_instr(15'o40005, 1'b1, 12'h803);
    step = 1'b1; instr_ready = 1'b1;
    tick(); step = 1'b0; n = 1;
    while (!instr_valid && n < 20) begin tick(); n++; end
    measure(3, n, 7);
    probe(3, S_WORD, 32'o40005); probe(3, S_EXT, 1);
    tick(); instr_ready = 1'b0;

    // T4: run with stalled execute, then run dropped mid-fetch
    rom[12'h800] = mk(15'o24001);
    rom[12'h801] = mk(15'o50003);
    do_reset();
    expect_instr(15'o24001, 1'b0, 12'h801);
    expect_instr(15'o50003, 1'b0, 12'h802);
    run = 1'b1;
    tick(); tick(); tick();
    probe(4, S_VLD, 1);
    repeat (10) begin
      tick();
      probe(4, S_VLD, 1); probe(4, S_WORD, 32'o24001); probe(4, S_CS, 0);
    end
    instr_ready = 1'b1;
    tick();
    probe(4, S_CS, 1); probe(4, S_ADDR, 32'h801);
    run = 1'b0;
    tick(); tick(); tick();
    probe(4, S_VLD, 0); probe(4, S_CS, 0);
    tick();
    probe(4, S_CS, 0); probe(4, S_PC, 32'h802);
    instr_ready = 1'b0;

    // T5: jump to FFF on accept, PC wraps to 000
    rom[12'h800] = mk(15'o10000);
    rom[12'hFFF] = mk(15'o60007);
    rom[12'h000] = mk(15'o70001);
    do_reset();
    expect_instr(15'o10000, 1'b0, 12'h801);
    expect_instr(15'o60007, 1'b0, 12'h000);
    expect_instr(15'o70001, 1'b0, 12'h001);
    step = 1'b1; run = 1'b1; instr_ready = 1'b1; jump_en = 1'b1; jump_addr = 12'hFFF;
    tick(); step = 1'b0;
    tick(); tick();
    tick();
    probe(5, S_ADDR, 32'hFFF); probe(5, S_CS, 1);
    jump_en = 1'b0;
    tick(); tick();
    probe(5, S_PC, 32'h000);
    tick();
    probe(5, S_ADDR, 32'h000);
    run = 1'b0;
    tick(); tick(); tick(); tick();
    probe(5, S_PC, 32'h001); probe(5, S_VLD, 0);
    instr_ready = 1'b0;

    // T6: reset during CAPTURE after EXTEND clears the pending prefix
    rom[12'h800] = mk(15'o00006);
    rom[12'h801] = mk(15'o20003);
    do_reset();
    step = 1'b1; instr_ready = 1'b1;
    tick(); step = 1'b0;
    tick(); tick();
    probe(6, S_ADDR, 32'h801); probe(6, S_CS, 1);
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    probe(6, S_PC, 32'h800); probe(6, S_VLD, 0); probe(6, S_CS, 0);
    rom[12'h800] = mk(15'o20003);
    expect_instr(15'o20003, 1'b0, 12'h801);
    step = 1'b1;
    tick();
    tick(); step = 1'b0;  // step seen in FETCH must be dropped
    tick(); tick(); tick();
    probe(6, S_CS, 0);
    tick();
    probe(6, S_CS, 0); probe(6, S_VLD, 0); probe(6, S_PC, 32'h801);
    instr_ready = 1'b0;

`ifdef ACC_PARITY_CHECK_EN
    // T7: even-parity word latches parity_err and parks the FSM
    rom[12'h800] = {^15'o30012, 15'o30012};
    do_reset();
    instr_ready = 1'b1;
    step = 1'b1;
    tick(); step = 1'b0;
    tick(); tick();
    probe(7, S_PERR, 1); probe(7, S_VLD, 0); probe(7, S_CS, 0);
    step = 1'b1;
    tick(); step = 1'b0;
    probe(7, S_CS, 0);
    tick(); probe(7, S_CS, 0); probe(7, S_VLD, 0);
    tick(); probe(7, S_CS, 0); probe(7, S_PERR, 1);
    do_reset();
    probe(7, S_PERR, 0); probe(7, S_PC, 32'h800);
`endif

    n = 0;
    while (instr_q.size() != 0 && n < 50) begin tick(); n++; end
    measure(99, instr_q.size(), 0);
    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
